// File: rtl/back_place_select_if.sv
// back_place_select_if: request, placement result and occupancy write-back bundle.
interface back_place_select_if;
  logic        in_valid;
  logic [3:0]  str_id_1, str_id_2, str_id_3;
  logic [7:0]  occ_width_1, occ_width_2, occ_width_3;
  logic [4:0]  width_in, height_in;
  logic        place_valid, place_fail;
  logic [3:0]  place_strip;
  logic [7:0]  place_x;
  logic [4:0]  place_height;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] place_cnt, fail_cnt;
  modport master (
    output in_valid, str_id_1, str_id_2, str_id_3, occ_width_1, occ_width_2, occ_width_3, width_in, height_in,
    input  place_valid, place_fail, place_strip, place_x, place_height, wr_en, wr_addr, wr_data, place_cnt, fail_cnt
  );
  modport slave (
    input  in_valid, str_id_1, str_id_2, str_id_3, occ_width_1, occ_width_2, occ_width_3, width_in, height_in,
    output place_valid, place_fail, place_strip, place_x, place_height, wr_en, wr_addr, wr_data, place_cnt, fail_cnt
  );
endinterface

// File: rtl/back_place_select.sv
// back_place_select: best-fit strip choice among three candidates, with occupancy write-back.
// BACK_PLACE_FWD_EN enables forwarding of the last two writes over stale occupancy.
module back_place_select #(
  parameter logic [7:0] STRIP_WIDTH = 8'd128
) (
  input logic clk,
  input logic rst,
  back_place_select_if.slave bus
);
  logic        place_valid_q, place_valid_d, place_fail_q, place_fail_d;
  logic [3:0]  place_strip_q, place_strip_d;
  logic [7:0]  place_x_q, place_x_d;
  logic [4:0]  place_height_q, place_height_d;
  logic        wr_en_q, wr_en_d;
  logic [3:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [15:0] place_cnt_q, place_cnt_d, fail_cnt_q, fail_cnt_d;
  logic [3:0]  id [3];
  logic [7:0]  raw [3];
  logic [7:0]  occ [3];
  logic [8:0]  sum [3];
  logic        sel_v;
  logic [1:0]  sel_i;
  logic [8:0]  sel_sum;
  logic        ok;
`ifdef BACK_PLACE_FWD_EN
  // Older history entry; the newest one is the registered write port itself.
  logic        h2_v_q, h2_v_d;
  logic [3:0]  h2_a_q, h2_a_d;
  logic [7:0]  h2_d_q, h2_d_d;
`endif
  always_comb begin
    id = '{bus.str_id_1, bus.str_id_2, bus.str_id_3};
    raw = '{bus.occ_width_1, bus.occ_width_2, bus.occ_width_3};
    sel_v = 1'b0;
    sel_i = 2'd0;
    sel_sum = 9'd0;
    for (int i = 0; i < 3; i++) begin
`ifdef BACK_PLACE_FWD_EN
      occ[i] = (wr_en_q && wr_addr_q == id[i]) ? wr_data_q : (h2_v_q && h2_a_q == id[i]) ? h2_d_q : raw[i];
`else
      occ[i] = raw[i];
`endif
      sum[i] = {1'b0, occ[i]} + {4'b0, bus.width_in};
      if (id[i] != 4'd0 && sum[i] <= {1'b0, STRIP_WIDTH} && (!sel_v || sum[i] > sel_sum)) begin
        sel_v = 1'b1;
        sel_i = 2'(i);
        sel_sum = sum[i];
      end
    end
    ok = bus.in_valid && sel_v;
    place_valid_d = bus.in_valid;
    place_fail_d = bus.in_valid ? !sel_v : place_fail_q;
    place_strip_d = bus.in_valid ? (sel_v ? id[sel_i] : 4'd0) : place_strip_q;
    place_x_d = bus.in_valid ? (sel_v ? occ[sel_i] : 8'd0) : place_x_q;
    place_height_d = bus.in_valid ? bus.height_in : place_height_q;
    wr_en_d = ok;
    wr_addr_d = place_strip_d;
    wr_data_d = ok ? sel_sum[7:0] : wr_data_q;
    place_cnt_d = (ok && place_cnt_q != 16'hFFFF) ? place_cnt_q + 16'd1 : place_cnt_q;
    fail_cnt_d = (bus.in_valid && !sel_v && fail_cnt_q != 16'hFFFF) ? fail_cnt_q + 16'd1 : fail_cnt_q;
`ifdef BACK_PLACE_FWD_EN
    h2_v_d = wr_en_q;
    h2_a_d = wr_addr_q;
    h2_d_d = wr_data_q;
`endif
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      place_valid_q <= 1'b0;
      place_fail_q <= 1'b0;
      place_strip_q <= 4'd0;
      place_x_q <= 8'd0;
      place_height_q <= 5'd0;
      wr_en_q <= 1'b0;
      wr_addr_q <= 4'd0;
      wr_data_q <= 8'd0;
      place_cnt_q <= 16'd0;
      fail_cnt_q <= 16'd0;
`ifdef BACK_PLACE_FWD_EN
      h2_v_q <= 1'b0;
      h2_a_q <= 4'd0;
      h2_d_q <= 8'd0;
`endif
    end else begin
      place_valid_q <= place_valid_d;
      place_fail_q <= place_fail_d;
      place_strip_q <= place_strip_d;
      place_x_q <= place_x_d;
      place_height_q <= place_height_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      place_cnt_q <= place_cnt_d;
      fail_cnt_q <= fail_cnt_d;
`ifdef BACK_PLACE_FWD_EN
      h2_v_q <= h2_v_d;
      h2_a_q <= h2_a_d;
      h2_d_q <= h2_d_d;
`endif
    end
  assign bus.place_valid = place_valid_q;
  assign bus.place_fail = place_fail_q;
  assign bus.place_strip = place_strip_q;
  assign bus.place_x = place_x_q;
  assign bus.place_height = place_height_q;
  assign bus.wr_en = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.place_cnt = place_cnt_q;
  assign bus.fail_cnt = fail_cnt_q;
endmodule
